ram_rx_arb: RTL and testbench

Two-requester arbiter and burst sequencer for the single read port of the receive command RAM. It lets the command reader and a second client (status/diagnostic reader) each fetch a contiguous burst of bytes over the shared `ram_rxa`/`ram_rxd` port. It handles fixed RAM read latency, round-robin fairness and the team's fs/fd level handshake. It sits between the receive RAM and its readers in the com subsystem.

---
 rtl/ram_rx_arb.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_rx_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rx_arb.sv
// ---------------------------------------------------------------------------
// ram_rx_arb
//
// Purpose:
//   Arbitrates the single read port of the receive command RAM between two
//   burst readers (requester 0 = command reader, requester 1 = status or
//   diagnostic reader). The winner gets one contiguous burst of bytes. The
//   block drives one address per cycle, tracks the fixed RAM read latency
//   with a valid shift register and returns data with a per-requester strobe.
//   Completion uses the fs/fd level handshake.
//
// Parameters:
//   DATA_LATENCY  - cycles from a ram_rxa change to the matching ram_rxd (1..4)
//   RAM_ADDR_INIT - value driven on ram_rxa while no address is being issued
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous reset, active low
//   fs_req0/1        requester start level, held until its fd_req is seen
//   fd_req0/1        burst done level, held until fs_req drops
//   addr0/1          burst start address, sampled at grant
//   len0/1           burst length in bytes, sampled at grant (0 is legal)
//   dv0/1            one-cycle strobe: rd_data is valid for that requester
//   rd_data          registered read data, shared by both requesters
//   ram_rxa          registered RAM read address
//   ram_rxd          RAM read data
//
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module ram_rx_arb #(
  parameter int         DATA_LATENCY  = 2,
  parameter logic [7:0] RAM_ADDR_INIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fs_req0,
  input  logic       fs_req1,
  output logic       fd_req0,
  output logic       fd_req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  output logic       dv0,
  output logic       dv1,
  output logic [7:0] rd_data,
  output logic [7:0] ram_rxa,
  input  logic [7:0] ram_rxd
);

  // One-hot burst sequencer states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  state_t                  state_q,   state_d;
  logic                    gnt_q,     gnt_d;
  logic                    last_q,    last_d;
  logic [7:0]              base_q,    base_d;
  logic [7:0]              cnt_max_q, cnt_max_d;
  logic [7:0]              k_q,       k_d;
  logic [DATA_LATENCY-1:0] sr_q,      sr_d;
  logic [7:0]              ram_rxa_q, ram_rxa_d;
  logic [7:0]              rd_data_q, rd_data_d;
  logic [1:0]              dv_q,      dv_d;
  logic [1:0]              fd_q,      fd_d;

  logic                    win_s;
  logic [7:0]              win_addr_s;
  logic [7:0]              win_len_s;
  logic                    fs_gnt_s;
  logic                    issue_s;
  logic                    sr_busy_s;

  // Round-robin pick: a lone requester wins, on a tie the side that was not
  // granted last time wins.
  always_comb begin
    if (fs_req0 && fs_req1) begin
      win_s = ~last_q;
    end else begin
      win_s = fs_req1;
    end
    if (win_s) begin
      win_addr_s = addr1;
      win_len_s  = len1;
    end else begin
      win_addr_s = addr0;
      win_len_s  = len0;
    end
    if (gnt_q) begin
      fs_gnt_s = fs_req1;
    end else begin
      fs_gnt_s = fs_req0;
    end
  end

  // Any tag that still has at least one more shift before emerging. The
  // oldest stage is excluded because it empties on the capture edge itself,
  // which lets DRAIN leave on the edge of the last capture.
  always_comb begin
    sr_busy_s = 1'b0;
    for (int i = 0; i < DATA_LATENCY - 1; i++) begin
      sr_busy_s = sr_busy_s | sr_q[i];
    end
  end

  // Sequencer next state, grant/burst bookkeeping, address and fd generation
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    base_d    = base_q;
    cnt_max_d = cnt_max_q;
    k_d       = k_q;
    ram_rxa_d = RAM_ADDR_INIT;
    issue_s   = 1'b0;
    fd_d      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (fs_req0 || fs_req1) begin
          gnt_d     = win_s;
          last_d    = win_s;
          base_d    = win_addr_s;
          cnt_max_d = win_len_s;
          k_d       = 8'd0;
          // A zero-length burst skips the RAM entirely.
          if (win_len_s == 8'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // 8-bit add wraps 8'hFF -> 8'h00 on purpose.
        ram_rxa_d = base_q + k_q;
        issue_s   = 1'b1;
        k_d       = k_q + 8'd1;
        if (k_q == (cnt_max_q - 8'd1)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (!sr_busy_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        // fd is only held while the granted requester keeps fs high; the
        // first cycle fs is seen low releases the port.
        if (fs_gnt_s) begin
          fd_d[gnt_q] = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read-latency tag pipeline and data return
  always_comb begin
    sr_d[0] = issue_s;
    for (int i = 1; i < DATA_LATENCY; i++) begin
      sr_d[i] = sr_q[i-1];
    end
    dv_d      = 2'b00;
    rd_data_d = rd_data_q;
    // The grant cannot change while tags are in flight, so gnt_q steers dv.
    if (sr_q[DATA_LATENCY-1]) begin
      rd_data_d   = ram_rxd;
      dv_d[gnt_q] = 1'b1;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      base_q    <= 8'h00;
      cnt_max_q <= 8'h00;
      k_q       <= 8'h00;
      sr_q      <= {DATA_LATENCY{1'b0}};
      ram_rxa_q <= RAM_ADDR_INIT;
      rd_data_q <= 8'h00;
      dv_q      <= 2'b00;
      fd_q      <= 2'b00;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      base_q    <= base_d;
      cnt_max_q <= cnt_max_d;
      k_q       <= k_d;
      sr_q      <= sr_d;
      ram_rxa_q <= ram_rxa_d;
      rd_data_q <= rd_data_d;
      dv_q      <= dv_d;
      fd_q      <= fd_d;
    end
  end

  assign ram_rxa = ram_rxa_q;
  assign rd_data = rd_data_q;
  assign dv0     = dv_q[0];
  assign dv1     = dv_q[1];
  assign fd_req0 = fd_q[0];
  assign fd_req1 = fd_q[1];

endmodule

// File: tb/tb_ram_rx_arb.sv
// ---------------------------------------------------------------------------
// tb_ram_rx_arb
//
// Bench for ram_rx_arb. The main instance uses DATA_LATENCY = 2. A second
// instance uses DATA_LATENCY = 4 and pins the long-latency timing. The RAM
// returns addr ^ 8'h5A after the configured latency. A timeline model
// (grant edge + offset arithmetic) predicts every output after every edge.
// Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_ram_rx_arb;

  localparam int         DL   = 2;
  localparam logic [7:0] INIT = 8'h80;

  logic       clk;
  logic       rst;
  logic       fs_req0, fs_req1;
  logic       fd_req0, fd_req1;
  logic [7:0] addr0, addr1, len0, len1;
  logic       dv0, dv1;
  logic [7:0] rd_data, ram_rxa, ram_rxd;

  logic       fs_b;
  logic       fd_b0, fd_b1, dv_b0, dv_b1;
  logic [7:0] rd_data_b, ram_rxa_b, ram_rxd_b;

  int n_chk  = 0;
  int n_pass = 0;

  ram_rx_arb #(.DATA_LATENCY(DL), .RAM_ADDR_INIT(INIT)) dut (
    .clk(clk), .rst(rst),
    .fs_req0(fs_req0), .fs_req1(fs_req1),
    .fd_req0(fd_req0), .fd_req1(fd_req1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .dv0(dv0), .dv1(dv1), .rd_data(rd_data),
    .ram_rxa(ram_rxa), .ram_rxd(ram_rxd)
  );

  ram_rx_arb #(.DATA_LATENCY(4), .RAM_ADDR_INIT(INIT)) dut_b (
    .clk(clk), .rst(rst),
    .fs_req0(fs_b), .fs_req1(1'b0),
    .fd_req0(fd_b0), .fd_req1(fd_b1),
    .addr0(8'h40), .addr1(8'h00), .len0(8'd1), .len1(8'd0),
    .dv0(dv_b0), .dv1(dv_b1), .rd_data(rd_data_b),
    .ram_rxa(ram_rxa_b), .ram_rxd(ram_rxd_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ram_f(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // RAM models: ram_rxd follows ram_rxa by the instance's latency
  logic [7:0] hist_a [0:3];
  logic [7:0] hist_b [0:3];
  initial begin
    for (int i = 0; i < 4; i++) begin
      hist_a[i] = 8'h00;
      hist_b[i] = 8'h00;
    end
  end
  always @(posedge clk) begin
    hist_a[0] <= ram_rxa;
    hist_b[0] <= ram_rxa_b;
    for (int i = 1; i < 4; i++) begin
      hist_a[i] <= hist_a[i-1];
      hist_b[i] <= hist_b[i-1];
    end
  end
  assign ram_rxd   = ram_f(hist_a[DL-2]);
  assign ram_rxd_b = ram_f(hist_b[2]);

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- timeline model of the main instance ----------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} mph_t;
  mph_t       ph     = M_IDLE;
  logic       m_last = 1'b1;
  logic       m_gnt  = 1'b0;
  logic [7:0] m_base = 8'h00;
  int         m_len  = 0;
  int         ecnt   = 0;
  int         g_edge = 0;
  int         off    = 0;
  logic [7:0] e_rxa  = INIT;
  logic [7:0] e_data = 8'h00;
  logic [1:0] e_dv   = 2'b00;
  logic [1:0] e_fd   = 2'b00;

  // Expected outputs after each edge, from grant edge and offset
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph = M_IDLE; m_last = 1'b1;
      e_rxa = INIT; e_data = 8'h00; e_dv = 2'b00; e_fd = 2'b00;
    end else begin
      ecnt++;
      e_rxa = INIT; e_dv = 2'b00; e_fd = 2'b00;
      case (ph)
        M_IDLE: begin
          if (fs_req0 || fs_req1) begin
            m_gnt  = (fs_req0 && fs_req1) ? ~m_last : fs_req1;
            m_last = m_gnt;
            m_base = m_gnt ? addr1 : addr0;
            m_len  = m_gnt ? int'(len1) : int'(len0);
            g_edge = ecnt;
            ph     = (m_len == 0) ? M_DONE : M_BUSY;
          end
        end
        M_BUSY: begin
          off = ecnt - g_edge;
          if (off <= m_len) e_rxa = m_base + 8'(off - 1);
          if (off >= DL + 1 && off <= DL + m_len) begin
            e_dv[m_gnt] = 1'b1;
            e_data      = ram_f(m_base + 8'(off - DL - 1));
          end
          if (off == DL + m_len) ph = M_DONE;
        end
        default: begin
          if (m_gnt ? fs_req1 : fs_req0) e_fd[m_gnt] = 1'b1;
          else ph = M_IDLE;
        end
      endcase
    end
  end

  // Logs for literal checks of the directed sequences
  int q_rxa [$];
  int q_d0  [$];
  int q_d1  [$];
  int q_ord [$];
  int n_fd0_hi = 0;

  task automatic clear_logs();
    q_rxa.delete(); q_d0.delete(); q_d1.delete(); q_ord.delete();
    n_fd0_hi = 0;
  endtask

  // Per-cycle compare against the model, plus logging
  always @(negedge clk) begin
    chk8("ram_rxa", ram_rxa, e_rxa);
    chk1("dv0", dv0, e_dv[0]);
    chk1("dv1", dv1, e_dv[1]);
    chk1("fd_req0", fd_req0, e_fd[0]);
    chk1("fd_req1", fd_req1, e_fd[1]);
    chk8("rd_data", rd_data, e_data);
    if (rst) begin
      if (ram_rxa !== INIT) q_rxa.push_back(int'(ram_rxa));
      if (dv0) begin q_d0.push_back(int'(rd_data)); q_ord.push_back(0); end
      if (dv1) begin q_d1.push_back(int'(rd_data)); q_ord.push_back(1); end
      if (fd_req0) n_fd0_hi++;
    end
  end

  // Full fs/fd handshake for one side, with bounded waits
  task automatic do_burst(input int side, input logic [7:0] a, input logic [7:0] l);
    int t;
    if (side == 0) begin addr0 = a; len0 = l; fs_req0 = 1'b1; end
    else begin addr1 = a; len1 = l; fs_req1 = 1'b1; end
    t = 0;
    while (((side == 0) ? fd_req0 : fd_req1) !== 1'b1 && t < 200) begin
      @(negedge clk); t++;
    end
    chk1($sformatf("fd_rise_side%0d", side), (side == 0) ? fd_req0 : fd_req1, 1'b1);
    if (side == 0) fs_req0 = 1'b0; else fs_req1 = 1'b0;
    t = 0;
    while (((side == 0) ? fd_req0 : fd_req1) !== 1'b0 && t < 20) begin
      @(negedge clk); t++;
    end
    chk1($sformatf("fd_fall_side%0d", side), (side == 0) ? fd_req0 : fd_req1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b0; fs_req0 = 1'b0; fs_req1 = 1'b0; fs_b = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; len0 = 8'd0; len1 = 8'd0;
    repeat (3) @(negedge clk);
    chk8("reset_rxa_lit", ram_rxa, 8'h80);
    chk8("reset_rd_data_lit", rd_data, 8'h00);
    chk1("reset_fd0_lit", fd_req0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous requests from reset: 0 first, then 1; twice
    clear_logs();
    fork
      do_burst(0, 8'h10, 8'd2);
      do_burst(1, 8'h20, 8'd2);
    join
    repeat (2) @(negedge clk);
    chki("tie1_order_n", q_ord.size(), 4);
    chki("tie1_order0", q_ord[0], 0);
    chki("tie1_order2", q_ord[2], 1);
    chki("tie1_d1_first", q_d1[0], 8'h7A);
    clear_logs();
    fork
      do_burst(0, 8'h30, 8'd2);
      do_burst(1, 8'h40, 8'd2);
    join
    repeat (2) @(negedge clk);
    chki("tie2_order0", q_ord[0], 0);
    chki("tie2_order3", q_ord[3], 1);

    // Single burst 85/4
    clear_logs();
    do_burst(0, 8'h85, 8'd4);
    repeat (2) @(negedge clk);
    chki("single_rxa_n", q_rxa.size(), 4);
    chki("single_rxa0", q_rxa[0], 8'h85);
    chki("single_rxa3", q_rxa[3], 8'h88);
    chki("single_d0_n", q_d0.size(), 4);
    chki("single_d0_0", q_d0[0], 8'hDF);
    chki("single_d0_1", q_d0[1], 8'hDC);
    chki("single_d0_2", q_d0[2], 8'hDD);
    chki("single_d0_3", q_d0[3], 8'hD2);
    chk8("single_idle_rxa", ram_rxa, 8'h80);

    // Address wrap on requester 1
    clear_logs();
    do_burst(1, 8'hFE, 8'd3);
    repeat (2) @(negedge clk);
    chki("wrap_rxa1", q_rxa[1], 8'hFF);
    chki("wrap_rxa2", q_rxa[2], 8'h00);
    chki("wrap_d1_n", q_d1.size(), 3);
    chki("wrap_d0_n", q_d0.size(), 0);

    // Zero length: fd after E1, nothing issued
    clear_logs();
    addr0 = 8'h55; len0 = 8'd0; fs_req0 = 1'b1;
    @(negedge clk);
    chk1("zero_fd_after_e0", fd_req0, 1'b0);
    @(negedge clk);
    chk1("zero_fd_after_e1", fd_req0, 1'b1);
    fs_req0 = 1'b0;
    @(negedge clk);
    chk1("zero_fd_fall", fd_req0, 1'b0);
    chki("zero_rxa_n", q_rxa.size(), 0);
    chki("zero_d0_n", q_d0.size(), 0);

    // fs dropped mid-burst: burst completes, fd never asserted
    clear_logs();
    addr0 = 8'h20; len0 = 8'd3; fs_req0 = 1'b1;
    repeat (2) @(negedge clk);
    fs_req0 = 1'b0;
    repeat (10) @(negedge clk);
    chki("drop_d0_n", q_d0.size(), 3);
    chki("drop_d0_0", q_d0[0], 8'h7A);
    chki("drop_fd0_cycles", n_fd0_hi, 0);

    // Reset during ISSUE
    addr0 = 8'h30; len0 = 8'd8; fs_req0 = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk8("rst_mid_rxa", ram_rxa, 8'h80);
    chk8("rst_mid_rd_data", rd_data, 8'h00);
    chk1("rst_mid_dv0", dv0, 1'b0);
    chk1("rst_mid_fd0", fd_req0, 1'b0);
    fs_req0 = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    clear_logs();
    do_burst(0, 8'h10, 8'd2);
    repeat (2) @(negedge clk);
    chki("post_rst_d0_0", q_d0[0], 8'h4A);
    chki("post_rst_d0_1", q_d0[1], 8'h4B);

    // DATA_LATENCY = 4, len = 1: first dv after E5
    fs_b = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      chk1($sformatf("lat4_dv_e%0d", n), dv_b0, (n == 5));
      chk8($sformatf("lat4_rxa_e%0d", n), ram_rxa_b, (n == 1) ? 8'h40 : 8'h80);
    end
    chk8("lat4_rd_data", rd_data_b, 8'h1A);
    t = 0;
    while (fd_b0 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    chk1("lat4_fd_rise", fd_b0, 1'b1);
    chk1("lat4_dv1_never", dv_b1, 1'b0);
    fs_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("lat4_fd_fall", fd_b0, 1'b0);
    chk1("lat4_fd1_never", fd_b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
